gan_inference_sequencer: RTL and testbench

GAN_INFERENCE_SEQUENCER -- requirements
Module: gan_inference_sequencer

---
 rtl/gan_seq_pkg.sv | 20 ++
 rtl/gan_inference_sequencer_if.sv | 40 ++++
 rtl/gan_lfsr16.sv | 23 ++
 rtl/gan_inference_sequencer.sv | 123 ++++++++++++
 tb/tb_gan_inference_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gan_seq_pkg.sv
// Shared types and constants for the GAN inference sequencer.
// Includes the Galois LFSR step used for generated noise.
package gan_seq_pkg;
   localparam int          Q15_W      = 16;
   localparam int          NUM_PIXELS = 9;
   localparam int          NUM_WORDS  = 10;
   localparam logic [15:0] LFSR_MASK  = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_STREAM
   } seq_state_e;

   // Galois form: shift right, fold the mask in when a one falls out.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction
endpackage

// File: rtl/gan_inference_sequencer_if.sv
// Command, GAN-core and result-stream signals of the sequencer.
// The slave modport is the sequencer; master is the surrounding system.
interface gan_inference_sequencer_if;
   import gan_seq_pkg::*;

   logic                        cmd_valid;
   logic                        cmd_ready;
   logic                        cmd_mode;
   logic [Q15_W-1:0]            cmd_noise_0;
   logic [Q15_W-1:0]            cmd_noise_1;
   logic [7:0]                  cmd_count;
   logic                        cmd_abort;
   logic                        gan_start;
   logic [Q15_W-1:0]            gan_noise_0;
   logic [Q15_W-1:0]            gan_noise_1;
   logic [NUM_PIXELS*Q15_W-1:0] gan_image;
   logic [Q15_W-1:0]            gan_disc_prob;
   logic                        gan_done;
   logic                        out_valid;
   logic                        out_ready;
   logic [Q15_W-1:0]            out_data;
   logic [3:0]                  out_index;
   logic                        out_last;
   logic                        busy;
   logic                        timeout_err;

   modport slave (
      input  cmd_valid, cmd_mode, cmd_noise_0, cmd_noise_1, cmd_count, cmd_abort,
      input  gan_image, gan_disc_prob, gan_done, out_ready,
      output cmd_ready, gan_start, gan_noise_0, gan_noise_1,
      output out_valid, out_data, out_index, out_last, busy, timeout_err
   );

   modport master (
      output cmd_valid, cmd_mode, cmd_noise_0, cmd_noise_1, cmd_count, cmd_abort,
      output gan_image, gan_disc_prob, gan_done, out_ready,
      input  cmd_ready, gan_start, gan_noise_0, gan_noise_1,
      input  out_valid, out_data, out_index, out_last, busy, timeout_err
   );
endinterface

// File: rtl/gan_lfsr16.sv
// 16-bit Galois LFSR noise source; advances one step per enabled cycle.
// A zero seed would lock up, so it is replaced by 1.
module gan_lfsr16
   import gan_seq_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_step,
   output logic [15:0] o_state
);
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic [15:0] r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_state <= SEED_EFF;
      else if (i_step) r_state <= lfsr_step(r_state);
   end

   assign o_state = r_state;
endmodule

// File: rtl/gan_inference_sequencer.sv
// Runs a GAN core N times per command, supplying noise and streaming
// each generated image plus discriminator probability as 10 words.
module gan_inference_sequencer
   import gan_seq_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input logic                      clk,
   input logic                      rst_n,
   gan_inference_sequencer_if.slave bus
);
   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   seq_state_e       r_state;
   logic             r_mode;
   logic [7:0]       r_remaining;
   logic [TMR_W-1:0] r_timer;
   logic             r_timeout;
   logic [Q15_W-1:0] r_noise_0, r_noise_1, r_out_data;
   logic [3:0]       r_word;
   logic             r_last;
   logic [Q15_W-1:0] r_buf [NUM_WORDS];

   logic [Q15_W-1:0] w_lfsr;
   logic             w_abort, w_accept, w_hs, w_reload, w_lfsr_step;

   assign w_abort  = bus.cmd_abort && (r_state != ST_IDLE);
   assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);
   assign w_hs     = (r_state == ST_STREAM) && bus.out_ready && !w_abort;
   assign w_reload = w_hs && (r_word == 4'(NUM_WORDS - 1)) && (r_remaining > 8'd1);
   // LFSR noise takes two steps per run: one on entry to START, one during it.
   assign w_lfsr_step = (w_accept && bus.cmd_mode) || (w_reload && r_mode) ||
                        ((r_state == ST_START) && r_mode);

   gan_lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_step  (w_lfsr_step),
      .o_state (w_lfsr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mode      <= 1'b0;
         r_remaining <= '0;
         r_timer     <= '0;
         r_timeout   <= 1'b0;
         r_noise_0   <= '0;
         r_noise_1   <= '0;
         r_out_data  <= '0;
         r_word      <= '0;
         r_last      <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) r_buf[k] <= '0;
      end else if (w_abort) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.cmd_valid) begin
               r_mode      <= bus.cmd_mode;
               r_remaining <= (bus.cmd_count == 8'd0) ? 8'd1 : bus.cmd_count;
               r_timeout   <= 1'b0;
               r_state     <= ST_START;
               r_noise_0   <= bus.cmd_mode ? w_lfsr            : bus.cmd_noise_0;
               r_noise_1   <= bus.cmd_mode ? lfsr_step(w_lfsr) : bus.cmd_noise_1;
            end
            ST_START: begin
               r_state <= ST_WAIT;
               r_timer <= TMR_W'(1);
            end
            ST_WAIT: if (bus.gan_done) begin
               for (int k = 0; k < NUM_PIXELS; k++)
                  r_buf[k] <= bus.gan_image[k*Q15_W +: Q15_W];
               r_buf[NUM_WORDS-1] <= bus.gan_disc_prob;
               r_out_data <= bus.gan_image[Q15_W-1:0];
               r_word     <= '0;
               r_last     <= 1'b0;
               r_state    <= ST_STREAM;
            end else if (r_timer >= TMR_LAST) begin
               r_timeout   <= 1'b1;
               r_remaining <= '0;
               r_state     <= ST_IDLE;
            end else begin
               r_timer <= r_timer + TMR_W'(1);
            end
            ST_STREAM: if (bus.out_ready) begin
               if (r_word == 4'(NUM_WORDS - 1)) begin
                  if (r_remaining > 8'd1) begin
                     r_remaining <= r_remaining - 8'd1;
                     r_state     <= ST_START;
                     if (r_mode) begin
                        r_noise_0 <= w_lfsr;
                        r_noise_1 <= lfsr_step(w_lfsr);
                     end
                  end else begin
                     r_remaining <= '0;
                     r_state     <= ST_IDLE;
                  end
               end else begin
                  r_word     <= r_word + 4'd1;
                  r_out_data <= r_buf[r_word + 4'd1];
                  r_last     <= (r_word == 4'(NUM_WORDS - 2));
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = (r_state == ST_IDLE);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.gan_start   = (r_state == ST_START);
   assign bus.out_valid   = (r_state == ST_STREAM);
   assign bus.gan_noise_0 = r_noise_0;
   assign bus.gan_noise_1 = r_noise_1;
   assign bus.out_data    = r_out_data;
   assign bus.out_index   = r_word;
   assign bus.out_last    = r_last;
   assign bus.timeout_err = r_timeout;
endmodule

// File: tb/tb_gan_inference_sequencer.sv
// Randomised self-checking bench: a queue-based model of expected noise
// pairs and result words is compared against the sequencer every cycle.
module tb_gan_inference_sequencer;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gan_inference_sequencer_if bus ();
   gan_inference_sequencer_if bus2 ();

   gan_inference_sequencer #(.TIMEOUT_CYCLES(1024), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   gan_inference_sequencer #(.TIMEOUT_CYCLES(16), .LFSR_SEED(SEED)) dut_to (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   int   n_cmp = 0, n_err = 0, starts = 0, hs = 0, lasts = 0, runs_left = 0;
   int   core_lat = 20, ready_mode = 0;
   bit   core_en = 1'b1, core_fixed = 1'b1, expect_start = 1'b0;
   logic core_done = 1'b0, rst_done = 1'b0;
   logic [15:0] exp_words[$];
   logic [31:0] exp_noise[$];
   logic [31:0] cur_noise = '0;
   logic [15:0] m_lfsr = SEED;
   int   pat[6] = '{1, 0, 0, 1, 0, 1};

   assign bus.gan_done = core_done | rst_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   function automatic logic [15:0] gstep(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic chk_reset(input string name);
      chk({name, "_ctl"}, 32'({bus.cmd_ready, bus.gan_start, bus.out_valid,
                               bus.out_last, bus.busy, bus.timeout_err}), 32'b100000);
      chk({name, "_noise"}, {bus.gan_noise_0, bus.gan_noise_1}, 32'h0);
      chk({name, "_out"}, 32'({bus.out_data, bus.out_index}), 32'h0);
   endtask

   // out_ready: always, fixed stall pattern, or random
   initial begin
      int ph;
      ph = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       begin bus.out_ready = (pat[ph % 6] != 0); ph++; end
            default: bus.out_ready = 1'($urandom % 2);
         endcase
      end
   end

   // GAN core: answers each start after core_lat cycles, queues expected words
   initial begin
      logic [143:0] img;
      logic [15:0]  pr;
      bus.gan_image = '0;
      bus.gan_disc_prob = '0;
      forever begin
         @(negedge clk);
         if (core_en && bus.gan_start) begin
            repeat (core_lat) @(posedge clk);
            #1;
            for (int k = 0; k < 9; k++)
               img[k*16 +: 16] = core_fixed ? 16'(k + 1) : 16'($urandom);
            pr = core_fixed ? 16'h6000 : 16'($urandom);
            bus.gan_image = img;
            bus.gan_disc_prob = pr;
            core_done = 1'b1;
            for (int k = 0; k < 9; k++) exp_words.push_back(img[k*16 +: 16]);
            exp_words.push_back(pr);
            @(posedge clk); #1;
            core_done = 1'b0;
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      int idx;
      logic [31:0] np;
      if (rst_n) begin
         chk("ready_is_not_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
         if (expect_start) begin
            chk("no_gap_restart", 32'(bus.gan_start), 32'd1);
            expect_start = 1'b0;
         end
         if (bus.gan_start) begin
            starts++;
            runs_left--;
            if (exp_noise.size() == 0) miss("unexpected_gan_start");
            else begin
               np = exp_noise.pop_front();
               chk("gan_noise", {bus.gan_noise_0, bus.gan_noise_1}, np);
               cur_noise = np;
            end
         end else if (bus.busy) begin
            chk("noise_stable", {bus.gan_noise_0, bus.gan_noise_1}, cur_noise);
         end
         if (bus.out_valid) begin
            if (exp_words.size() == 0) miss("unexpected_out_valid");
            else begin
               idx = 10 - exp_words.size();
               chk("out_data", 32'(bus.out_data), 32'(exp_words[0]));
               chk("out_index", 32'(bus.out_index), idx);
               chk("out_last", 32'(bus.out_last), 32'(idx == 9));
               if (bus.out_ready) begin
                  void'(exp_words.pop_front());
                  hs++;
                  if (bus.out_last) lasts++;
                  if (idx == 9 && runs_left > 0) expect_start = 1'b1;
               end
            end
         end
      end
   end

   task automatic send_cmd(input bit mode, input logic [15:0] n0, input logic [15:0] n1,
                           input logic [7:0] cnt, input bit with_abort);
      int t, runs;
      t = 0;
      while (!bus.cmd_ready && t < 3000) begin @(posedge clk); #1; t++; end
      if (t >= 3000) miss("cmd_ready_wait");
      runs = (cnt == 8'd0) ? 1 : int'(cnt);
      for (int r = 0; r < runs; r++) begin
         if (mode) begin
            exp_noise.push_back({m_lfsr, gstep(m_lfsr)});
            m_lfsr = gstep(gstep(m_lfsr));
         end else exp_noise.push_back({n0, n1});
      end
      runs_left = runs;
      bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_noise_0 = n0;
      bus.cmd_noise_1 = n1; bus.cmd_count = cnt; bus.cmd_abort = with_abort;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_abort = 1'b0;
      chk("start_at_T+1", 32'(bus.gan_start), 32'd1);
      chk("timeout_cleared", 32'(bus.timeout_err), 32'd0);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      do begin @(posedge clk); #1; t++; end
      while ((bus.busy || exp_noise.size() != 0) && t < 6000);
      if (t >= 6000) miss("command_completion");
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("words_drained", exp_words.size(), 0);
   endtask

   initial begin
      int h0, s0, l0, c, t;
      bit saw, mode;
      logic [7:0] cnt;
      bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_noise_0 = '0;
      bus.cmd_noise_1 = '0; bus.cmd_count = '0; bus.cmd_abort = 1'b0;
      bus2.cmd_valid = 1'b0; bus2.cmd_mode = 1'b0; bus2.cmd_noise_0 = 16'h1111;
      bus2.cmd_noise_1 = 16'h2222; bus2.cmd_count = 8'd1; bus2.cmd_abort = 1'b0;
      bus2.gan_image = '0; bus2.gan_disc_prob = '0; bus2.gan_done = 1'b0;
      bus2.out_ready = 1'b1;
      #2;
      chk_reset("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // direct mode, single run, always ready
      h0 = hs; l0 = lasts; s0 = starts;
      send_cmd(1'b0, 16'h4000, 16'h4000, 8'd1, 1'b0);
      chk("direct_noise", {bus.gan_noise_0, bus.gan_noise_1}, 32'h40004000);
      wait_done();
      chk("direct_words", hs - h0, 10);
      chk("direct_lasts", lasts - l0, 1);
      chk("direct_starts", starts - s0, 1);

      // same run with stalls
      ready_mode = 1;
      h0 = hs; l0 = lasts;
      send_cmd(1'b0, 16'h4000, 16'h4000, 8'd1, 1'b0);
      wait_done();
      chk("stall_words", hs - h0, 10);
      chk("stall_lasts", lasts - l0, 1);

      // LFSR mode, three runs, random ready and image
      ready_mode = 2; core_fixed = 1'b0;
      h0 = hs; l0 = lasts; s0 = starts;
      send_cmd(1'b1, 16'h0, 16'h0, 8'd3, 1'b0);
      chk("lfsr_first_noise0", 32'(bus.gan_noise_0), 32'h0000ACE1);
      chk("lfsr_first_noise1", 32'(bus.gan_noise_1), 32'h0000E270);
      wait_done();
      chk("lfsr_starts", starts - s0, 3);
      chk("lfsr_words", hs - h0, 30);
      chk("lfsr_lasts", lasts - l0, 3);

      // abort after word-4 handshake, count 2
      ready_mode = 0; core_fixed = 1'b1;
      send_cmd(1'b0, 16'h1357, 16'h2468, 8'd2, 1'b0);
      t = 0;
      while (!(bus.out_valid && bus.out_index == 4'd5) && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 200) miss("abort_word5_wait");
      bus.cmd_abort = 1'b1;
      @(posedge clk); #1;
      bus.cmd_abort = 1'b0;
      exp_words.delete(); exp_noise.delete(); runs_left = 0;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_idle", 32'({bus.busy, bus.cmd_ready}), 32'b01);
      chk("abort_timeout_kept", 32'(bus.timeout_err), 32'd0);
      s0 = starts;
      repeat (40) @(posedge clk);
      #1 chk("abort_no_restart", starts - s0, 0);

      // reset during WAIT, gan_done while in reset
      core_en = 1'b0;
      send_cmd(1'b0, 16'h1234, 16'h5678, 8'd1, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset("midrun_reset");
      rst_done = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1; rst_done = 1'b0;
      exp_words.delete(); exp_noise.delete(); runs_left = 0; m_lfsr = SEED;
      core_en = 1'b1;
      repeat (30) @(posedge clk);
      #1 chk("post_reset_idle", 32'({bus.busy, bus.out_valid, bus.cmd_ready}), 32'b001);

      // random commands
      ready_mode = 2; core_fixed = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mode = 1'($urandom % 2);
         cnt = 8'($urandom % 4);
         core_lat = $urandom_range(1, 30);
         h0 = hs;
         send_cmd(mode, 16'($urandom), 16'($urandom), cnt, i == 0);
         wait_done();
         chk("rand_words", hs - h0, 10 * ((cnt == 8'd0) ? 1 : int'(cnt)));
      end

      // timeout instance
      bus2.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus2.cmd_valid = 1'b0;
      chk("to_start", 32'(bus2.gan_start), 32'd1);
      c = 0; saw = 1'b0;
      while (!bus2.timeout_err && c < 40) begin
         @(posedge clk); #1; c++;
         if (bus2.out_valid) saw = 1'b1;
      end
      chk("to_cycles_after_start", c, 16);
      chk("to_no_stream", 32'(saw), 32'd0);
      chk("to_idle", 32'({bus2.busy, bus2.cmd_ready}), 32'b01);
      bus2.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus2.cmd_valid = 1'b0;
      chk("to_cleared_on_accept", 32'(bus2.timeout_err), 32'd0);
      bus2.cmd_abort = 1'b1;
      @(posedge clk); #1;
      bus2.cmd_abort = 1'b0;
      chk("to_abort_idle", 32'({bus2.busy, bus2.timeout_err}), 32'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
